alu_bus_sequencer: RTL and testbench
====================================

# alu_bus_sequencer

Front-end sequencer for the ALU control unit. It accepts one operation request over a valid/ready handshake and pulses BEGIN for a single cycle. It then drives INBUS with the correct operand each time the control unit raises a load strobe, captures OUTBUS on each push strobe, and returns the assembled result over a valid/ready response port once END arrives.

## Interface
- `W`, default 8: datapath/register width (A, Q, M, INBUS, OUTBUS).
- `TIMEOUT_CYCLES`, default 64: maximum cycles in RUN before abort.

- `clk`  in  1  system clock.
- `reset_input`  in  1  synchronous reset, active-high. One clock drives the whole block.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_op`  in  2  00 add, 01 sub, 10 mul, 11 div.
- `req_x`  in  2W  operand X. For div, the full dividend; otherwise only `req_x[W-1:0]` is used.
- `req_y`  in  W  operand Y (addend, subtrahend, multiplier M, or divisor).
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed.
- `rsp_result`  out  2W  assembled result.
- `rsp_error`  out  2  00 ok, 01 timeout, 10 divide-by-zero.
- `alu_begin`  out  1  BEGIN to control unit.
- `alu_op_code`  out  2  op code to control unit.
- `alu_reset`  out  1  active-high reset to control unit.
- `inbus`  out  W  operand bus.
- `load_a`, `load_q`, `load_m`  in  1 each  load strobes from control unit.
- `push_a`, `push_q`  in  1 each  push strobes from control unit.
- `outbus`  in  W  result bus.
- `alu_end`  in  1  END from control unit.

## Operation
- FSM states: IDLE, ISSUE, RUN, ABORT, RESP.
- IDLE:
  - `req_ready`=1.
  - On handshake, latch op/X/Y into `op_r`, `x_r`, `y_r`, clear `cap_a`/`cap_q`/timeout counter, then go to ISSUE.
  - Div with Y==0 under `ALU_SEQ_DIVZERO_CHECK_EN` goes to RESP instead.
- ISSUE: `alu_begin`=1 for exactly this one cycle, then go to RUN.
- RUN:
  - On `alu_end`, go to RESP with error 00.
  - If the counter reaches `TIMEOUT_CYCLES`-1 without `alu_end`, go to ABORT.
- ABORT: `alu_reset`=1 for one cycle, then go to RESP with error 01.
- RESP: `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- `alu_op_code` = `op_r`, held stable from ISSUE through RESP.
- `inbus` is combinational and driven only in ISSUE/RUN:
  - When `load_a`: x_r[2W-1:W] for div, x_r[W-1:0] otherwise.
  - When `load_q`: x_r[W-1:0].
  - When `load_m`: y_r.
  - Priority is a > q > m. Otherwise `inbus`=0.
- Capture in RUN only: the rising edge with `push_a`=1 loads `cap_a`←outbus; with `push_q`=1, `cap_q`←outbus. Push strobes outside RUN are ignored.
- Result assembly:
  - add/sub: {W'b0, cap_a}.
  - mul: {cap_a, cap_q}.
  - div: {cap_a (remainder), cap_q (quotient)}.
  - Error responses: result 0.
- Arithmetic is W-bit modulo, as produced by the ALU. The sequencer performs no arithmetic beyond the counter.

## Timing
- Reset values:
  - state IDLE.
  - `req_ready`=0 while `reset_input` is high, 1 afterwards.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_error`=0.
  - `alu_begin`=0, `alu_op_code`=0, `inbus`=0.
  - `alu_reset`=1 while `reset_input` is high.
- Handshake at edge N → `alu_begin` high in cycle N+1 → RUN from N+2.
- `alu_end` sampled at edge E → `rsp_valid` high from E+1.
- Total latency = control unit latency + 2 cycles.
- `rsp_valid` and `rsp_result` are held until `rsp_ready`. No new request is accepted until the response is consumed.
- `alu_end` together with timeout expiry in the same cycle: `alu_end` wins and the error is 00.
- Reset asserted mid-operation: the next edge returns to IDLE, the captured data and any pending response are discarded, and `alu_reset` follows `reset_input`.
- Load and push strobes in the same cycle are both honoured.

## Configuration
- `ALU_SEQ_DIVZERO_CHECK_EN` defined:
  - Div with `req_y`==0 never starts the ALU (`alu_begin` stays 0).
  - The response follows one cycle after the handshake, with error 10 and result 0.
- Undefined: div by zero is issued normally, and the result is whatever the ALU returns (or a timeout).

## Test plan
- add X=100, Y=27 → `inbus` 100 on `load_a`, 27 on `load_m`; `rsp_result`=16'h007F, error 00.
- sub X=5, Y=7 → `rsp_result`=16'h00FE; `alu_begin` high for exactly one cycle.
- mul X=13, Y=11 → `inbus` 13 on `load_q`, 11 on `load_m`; `rsp_result`=16'h008F.
- div X=16'd1000, Y=7 → `inbus` 8'h03 on `load_a`, 8'hE8 on `load_q`; `rsp_result`=16'h068E.
- Fault and abort cases:
  - div Y=0 with the macro → error 10, `alu_begin` never asserted.
  - Control unit model never raises END → at cycle 64 of RUN, `alu_reset` pulses one cycle, then error 01.
- Backpressure and reset:
  - `rsp_ready` held low 5 cycles → `rsp_valid`/`rsp_result` stable and `req_ready`=0.
  - `reset_input` asserted mid-RUN → IDLE next cycle and `rsp_valid` never asserts.

Source files
------------

// File: rtl/alu_bus_sequencer.sv
// ---------------------------------------------------------------------------
// alu_bus_sequencer
//
// Front-end sequencer for the ALU control unit. It accepts one operation
// request and pulses alu_begin for a single cycle. While the control unit
// runs, it supplies operands on inbus in response to the load strobes and
// captures outbus on the push strobes. When alu_end arrives, it returns the
// assembled result on the response port. If alu_end never arrives, a
// watchdog pulses alu_reset and reports a timeout.
//
// Parameters
//   W               datapath / register width
//   TIMEOUT_CYCLES  maximum cycles spent in RUN before the operation aborts
//
// Ports
//   clk, reset_input           clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_op, req_x, req_y       op (00 add, 01 sub, 10 mul, 11 div), operands
//   rsp_valid/rsp_ready        response handshake
//   rsp_result, rsp_error      result, error (00 ok, 01 timeout, 10 div-by-0)
//   alu_begin, alu_op_code     start pulse and op code to the control unit
//   alu_reset                  reset to the control unit
//   inbus                      operand bus to the control unit
//   load_a/load_q/load_m       operand load strobes from the control unit
//   push_a/push_q, outbus      result push strobes and result bus
//   alu_end                    completion from the control unit
//   dbg_state                  current FSM state (debug observation)
//
// Optional feature
//   ALU_SEQ_DIVZERO_CHECK_EN   when defined, a div request with req_y == 0
//                              never starts the ALU. It is answered one cycle
//                              after the handshake with error 10 and result 0.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both high. Once valid is raised, it and its payload
// stay stable until that transfer.
// ---------------------------------------------------------------------------
module alu_bus_sequencer #(
    parameter int W              = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           reset_input,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_op,
    input  logic [2*W-1:0] req_x,
    input  logic [W-1:0]   req_y,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_result,
    output logic [1:0]     rsp_error,
    output logic           alu_begin,
    output logic [1:0]     alu_op_code,
    output logic           alu_reset,
    output logic [W-1:0]   inbus,
    input  logic           load_a,
    input  logic           load_q,
    input  logic           load_m,
    input  logic           push_a,
    input  logic           push_q,
    input  logic [W-1:0]   outbus,
    input  logic           alu_end,
    output logic [2:0]     dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_RUN   = 3'd2,
        S_ABORT = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [1:0] OP_MUL      = 2'b10;
    localparam logic [1:0] OP_DIV      = 2'b11;
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_DIVZERO = 2'b10;

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [1:0]       op_r;
    logic [2*W-1:0]   x_r;
    logic [W-1:0]     y_r;
    logic [W-1:0]     cap_a;
    logic [W-1:0]     cap_q;
    logic [CNT_W-1:0] cnt;
    logic             abort_r;

    logic             div_by_zero;
    logic             drive_phase;
    logic [W-1:0]     cap_a_nxt;
    logic [W-1:0]     cap_q_nxt;
    logic [2*W-1:0]   result_nxt;

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    assign div_by_zero = (req_op == OP_DIV) && (req_y == '0);
`else
    assign div_by_zero = 1'b0;
`endif

    // req_ready must drop the moment reset is asserted, so it is decoded
    // from the state register and gated with reset rather than registered.
    assign req_ready   = (state == S_IDLE) && !reset_input;
    assign alu_reset   = reset_input || abort_r;
    assign alu_op_code = op_r;
    assign dbg_state   = state;
    assign drive_phase = (state == S_ISSUE) || (state == S_RUN);

    // Captures that land on the same edge as alu_end still belong to this
    // result, so assembly uses the post-push values.
    assign cap_a_nxt = (state == S_RUN && push_a) ? outbus : cap_a;
    assign cap_q_nxt = (state == S_RUN && push_q) ? outbus : cap_q;

    always_comb begin
        result_nxt = '0;
        if (op_r == OP_MUL || op_r == OP_DIV) begin
            result_nxt = {cap_a_nxt, cap_q_nxt};
        end else begin
            result_nxt = {{W{1'b0}}, cap_a_nxt};
        end
    end

    // Operand mux: A takes the dividend's upper half for div, the low half
    // otherwise. Priority is a > q > m.
    always_comb begin
        inbus = '0;
        if (drive_phase) begin
            if (load_a) begin
                inbus = (op_r == OP_DIV) ? x_r[2*W-1:W] : x_r[W-1:0];
            end else if (load_q) begin
                inbus = x_r[W-1:0];
            end else if (load_m) begin
                inbus = y_r;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_input) begin
            state      <= S_IDLE;
            op_r       <= '0;
            x_r        <= '0;
            y_r        <= '0;
            cap_a      <= '0;
            cap_q      <= '0;
            cnt        <= '0;
            abort_r    <= 1'b0;
            alu_begin  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_error  <= '0;
        end else begin
            alu_begin <= 1'b0;
            abort_r   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_r  <= req_op;
                        x_r   <= req_x;
                        y_r   <= req_y;
                        cap_a <= '0;
                        cap_q <= '0;
                        cnt   <= '0;
                        if (div_by_zero) begin
                            state      <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_result <= '0;
                            rsp_error  <= ERR_DIVZERO;
                        end else begin
                            state     <= S_ISSUE;
                            alu_begin <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    cap_a <= cap_a_nxt;
                    cap_q <= cap_q_nxt;
                    // alu_end wins over a simultaneous timeout expiry.
                    if (alu_end) begin
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_result <= result_nxt;
                        rsp_error  <= ERR_OK;
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_ABORT;
                        abort_r <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ABORT: begin
                    state      <= S_RESP;
                    rsp_valid  <= 1'b1;
                    rsp_result <= '0;
                    rsp_error  <= ERR_TIMEOUT;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state      <= S_IDLE;
                        rsp_valid  <= 1'b0;
                        rsp_result <= '0;
                        rsp_error  <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_bus_sequencer
//
// Drives requests into alu_bus_sequencer. A behavioural control-unit model
// answers alu_begin with load/push strobes and alu_end. Expected responses
// are queued at request time, and a monitor compares them against the
// response port.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_bus_sequencer;

    localparam int W  = 8;
    localparam int W2 = 2 * W;
    localparam int TO = 64;

    // ---------------- clock / reset / DUT signals ----------------
    logic          clk = 1'b0;
    logic          reset_input;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [W2-1:0] req_x;
    logic [W-1:0]  req_y;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W2-1:0] rsp_result;
    logic [1:0]    rsp_error;
    logic          alu_begin;
    logic [1:0]    alu_op_code;
    logic          alu_reset;
    logic [W-1:0]  inbus;
    logic          load_a, load_q, load_m, push_a, push_q;
    logic [W-1:0]  outbus;
    logic          alu_end;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    alu_bus_sequencer #(.W(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_input(reset_input),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error),
        .alu_begin(alu_begin), .alu_op_code(alu_op_code), .alu_reset(alu_reset),
        .inbus(inbus), .load_a(load_a), .load_q(load_q), .load_m(load_m),
        .push_a(push_a), .push_q(push_q), .outbus(outbus), .alu_end(alu_end),
        .dbg_state(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    typedef struct {
        logic [1:0]    op;
        logic [W2-1:0] x;
        logic [W-1:0]  y;
        int            mode;   // 0 normal, 1 never ends, 2 interrupted by reset
    } txn_t;

    txn_t            cu_q[$];
    logic [W2+1:0]   exp_q[$];   // {error, result}
    int              checks    = 0;
    int              errors    = 0;
    bit              hold_rdy  = 1'b0;
    bit              cu_busy   = 1'b0;
    int              begin_cnt = 0;
    int              valid_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, event never seen, expected it (t=%0t)", name, $time);
    endtask

    // Reference model: plain arithmetic from the operation definitions.
    function automatic logic [W2+1:0] model(input logic [1:0] op, input logic [W2-1:0] x,
                                            input logic [W-1:0] y);
        longint m, xl, xf, yv, r;
        m  = longint'(1) << W;
        xl = longint'(x[W-1:0]);
        xf = longint'(x);
        yv = longint'(y);
        case (op)
            2'd0:    r = (xl + yv) % m;
            2'd1:    r = (xl - yv + m) % m;
            2'd2:    r = xl * yv;
            default: r = (yv == 0) ? 0 : ((xf % yv) % m) * m + ((xf / yv) % m);
        endcase
        return {2'b00, W2'(r)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [1:0] op, input logic [W2-1:0] x, input logic [W-1:0] y,
                            input int mode, input bit push_exp, input logic [W2+1:0] exp,
                            input bit to_cu);
        txn_t t;
        int   n;
        bit   hs;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_x     = x;
        req_y     = y;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 400) begin
            @(negedge clk);
            if (req_ready) hs = 1'b1;
            n++;
        end
        if (!hs) begin
            fail_bound("req_handshake");
        end else begin
            t.op = op; t.x = x; t.y = y; t.mode = mode;
            if (to_cu) cu_q.push_back(t);
            if (push_exp) exp_q.push_back(exp);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_x     = W2'($urandom);
        req_y     = W'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cu_busy) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || cu_busy) fail_bound("drain");
    endtask

    // ---------------- control-unit model ----------------
    task automatic cu_cycle(input logic la, input logic lq, input logic lm, input logic pa,
                            input logic pq, input logic [W-1:0] ob, input logic en);
        @(posedge clk); #1;
        load_a = la; load_q = lq; load_m = lm;
        push_a = pa; push_q = pq; outbus = ob; alu_end = en;
        @(negedge clk);
    endtask

    task automatic cu_gap(inout int cyc);
        int g;
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
            cu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'($urandom), 1'b0);
            cyc++;
            check("inbus_idle", 64'(inbus), 64'(0));
        end
    endtask

    task automatic run_cu(input txn_t t);
        logic [W2+1:0] r;
        logic [W-1:0]  ra, rq, exp_in;
        int            kinds[$];
        int            cyc;
        bit            ovl, last, extra;
        r   = model(t.op, t.x, t.y);
        ra  = (t.op < 2) ? r[W-1:0] : r[W2-1:W];
        rq  = r[W-1:0];
        ovl = 1'(($urandom_range(0, 1)));
        cyc = 0;
        cu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'($urandom), 1'b0);
        cyc++;
        check("begin_one_cycle", 64'(alu_begin), 64'(0));
        check("op_code", 64'(alu_op_code), 64'(t.op));
        case (t.op)
            2'd0, 2'd1: kinds = '{0, 2};
            2'd2:       kinds = '{1, 2};
            default:    kinds = '{0, 1, 2};
        endcase
        for (int i = 0; i < kinds.size(); i++) begin
            cu_gap(cyc);
            last  = (i == kinds.size() - 1);
            extra = 1'(($urandom_range(0, 1)));
            if (kinds[i] == 0)      exp_in = (t.op == 2'd3) ? t.x[W2-1:W] : t.x[W-1:0];
            else if (kinds[i] == 1) exp_in = t.x[W-1:0];
            else                    exp_in = t.y;
            // extra lower-priority strobes must not disturb the bus
            cu_cycle(kinds[i] == 0,
                     (kinds[i] == 1) || (kinds[i] == 0 && extra),
                     (kinds[i] == 2) || (kinds[i] != 2 && extra),
                     last && ovl, 1'b0, (last && ovl) ? ra : W'($urandom), 1'b0);
            cyc++;
            check("inbus_load", 64'(inbus), 64'(exp_in));
        end
        if (!ovl) begin
            cu_gap(cyc);
            cu_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ra, 1'b0);
            cyc++;
        end
        if (t.op >= 2'd2) begin
            cu_gap(cyc);
            cu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rq, 1'b0);
            cyc++;
        end
        if (t.mode == 0) begin
            cu_gap(cyc);
            cu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'($urandom), 1'b1);
            cu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'($urandom), 1'b0);
            check("rsp_valid_after_end", 64'(rsp_valid), 64'(1));
        end else if (t.mode == 1) begin
            while (!alu_reset && cyc < 200) begin
                cu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'($urandom), 1'b0);
                cyc++;
            end
            check("abort_cycle", 64'(cyc), 64'(TO + 1));
            cu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'($urandom), 1'b0);
            check("abort_pulse_width", 64'(alu_reset), 64'(0));
        end else begin
            cu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'($urandom), 1'b0);
        end
    endtask

    initial begin
        txn_t t;
        load_a = 1'b0; load_q = 1'b0; load_m = 1'b0;
        push_a = 1'b0; push_q = 1'b0; outbus = '0; alu_end = 1'b0;
        forever begin
            @(negedge clk);
            if (alu_begin) begin
                if (cu_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_begin: alu_begin=1 with no request pending, expected 0");
                end else begin
                    cu_busy = 1'b1;
                    t = cu_q.pop_front();
                    run_cu(t);
                    cu_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- response consumer ----------------
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    always @(negedge clk) begin
        if (alu_begin) begin_cnt++;
    end

    // ---------------- scoreboard monitor ----------------
    logic [W2+1:0] held;
    bit            holding = 1'b0;

    always @(negedge clk) begin
        logic [W2+1:0] e;
        if (rsp_valid) begin
            valid_cnt++;
            check("req_ready_in_resp", 64'(req_ready), 64'(0));
            if (holding) check("rsp_stable", 64'({rsp_error, rsp_result}), 64'(held));
            if (rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got result 0x%0h err %0d, expected no response",
                             rsp_result, rsp_error);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_result", 64'(rsp_result), 64'(e[W2-1:0]));
                    check("rsp_error", 64'(rsp_error), 64'(e[W2+1:W2]));
                end
                holding = 1'b0;
            end else begin
                holding = 1'b1;
                held    = {rsp_error, rsp_result};
            end
        end else begin
            holding = 1'b0;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [1:0]    op;
        logic [W2-1:0] x;
        logic [W-1:0]  y;
        logic [W2-1:0] saved;
        int            n, v0;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        int            b0;
`endif
        reset_input = 1'b1;
        req_valid   = 1'b0;
        req_op      = '0;
        req_x       = '0;
        req_y       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_alu_reset", 64'(alu_reset), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_result", 64'(rsp_result), 64'(0));
        check("rst_rsp_error", 64'(rsp_error), 64'(0));
        check("rst_alu_begin", 64'(alu_begin), 64'(0));
        check("rst_op_code", 64'(alu_op_code), 64'(0));
        check("rst_inbus", 64'(inbus), 64'(0));
        @(posedge clk); #1;
        reset_input = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 64'(req_ready), 64'(1));
        check("post_rst_alu_reset", 64'(alu_reset), 64'(0));

        // directed operations with hand-computed results
        send_req(2'd0, W2'(100),  W'(27), 0, 1'b1, {2'b00, 16'h007F}, 1'b1);
        send_req(2'd1, W2'(5),    W'(7),  0, 1'b1, {2'b00, 16'h00FE}, 1'b1);
        send_req(2'd2, W2'(13),   W'(11), 0, 1'b1, {2'b00, 16'h008F}, 1'b1);
        send_req(2'd3, W2'(1000), W'(7),  0, 1'b1, {2'b00, 16'h068E}, 1'b1);
        wait_drain();

        // backpressure: response must hold while rsp_ready stays low
        hold_rdy = 1'b1;
        x = W2'($urandom);
        y = W'($urandom);
        send_req(2'd2, x, y, 0, 1'b1, model(2'd2, x, y), 1'b1);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) fail_bound("bp_rsp_valid");
        saved = rsp_result;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid), 64'(1));
            check("bp_result", 64'(rsp_result), 64'(saved));
            check("bp_req_ready", 64'(req_ready), 64'(0));
        end
        hold_rdy = 1'b0;
        wait_drain();

        // control unit never raises END: timeout abort
        send_req(2'd2, W2'($urandom), W'($urandom), 1, 1'b1, {2'b01, 16'h0000}, 1'b1);
        wait_drain();

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        b0 = begin_cnt;
        send_req(2'd3, W2'($urandom), W'(0), 0, 1'b1, {2'b10, 16'h0000}, 1'b0);
        @(negedge clk);
        check("divzero_rsp_next_cycle", 64'(rsp_valid), 64'(1));
        wait_drain();
        check("divzero_no_begin", 64'(begin_cnt), 64'(b0));
`endif

        // randomized traffic
        for (int i = 0; i < 25; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'd3) begin
                y = W'($urandom_range(1, (1 << W) - 1));
                x = W2'($urandom_range(0, int'(y) * (1 << W) - 1));
            end else begin
                x = W2'($urandom);
                y = W'($urandom);
            end
            send_req(op, x, y, 0, 1'b1, model(op, x, y), 1'b1);
        end
        wait_drain();

        // reset in the middle of RUN: no response may ever appear
        v0 = valid_cnt;
        send_req(2'd0, W2'($urandom), W'($urandom), 2, 1'b0, '0, 1'b1);
        repeat (2) @(negedge clk);
        n = 0;
        while (cu_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (cu_busy) fail_bound("kill_cu_done");
        @(posedge clk); #1;
        reset_input = 1'b1;
        @(negedge clk);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(0));
        check("midrst_alu_reset", 64'(alu_reset), 64'(1));
        check("midrst_alu_begin", 64'(alu_begin), 64'(0));
        @(posedge clk); #1;
        reset_input = 1'b0;
        @(negedge clk);
        check("midrst_idle_ready", 64'(req_ready), 64'(1));
        check("midrst_alu_reset_rel", 64'(alu_reset), 64'(0));
        repeat (TO + 10) @(negedge clk);
        check("midrst_no_rsp", 64'(valid_cnt), 64'(v0));

        // recovery after the reset
        send_req(2'd0, W2'(200), W'(100), 0, 1'b1, {2'b00, 16'h002C}, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
